// File: rtl/conv_1d_feeder_if.sv
// Register-write, run-control and stream signals between conv_1d_feeder and its driver.
// The master side loads buffers and requests runs; the slave side is the feeder.
interface conv_1d_feeder_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          start;
    logic          conv_done;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          conv_rst;
    logic          sample_tick;
    logic          busy;
    logic          run_done;
    logic          timeout;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, conv_done,
        input  a, b, conv_rst, sample_tick, busy, run_done, timeout
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, conv_done,
        output a, b, conv_rst, sample_tick, busy, run_done, timeout
    );
endinterface

// File: rtl/conv_1d_feeder.sv
// Buffers one signal vector and one kernel, then streams them into conv_1d after a clean
// reset release, holding each index HOLD cycles, and waits for done or timeout.
//
// state   | meaning
// S_IDLE  | core held in reset, buffers writable, waiting for start
// S_PRIME | one cycle with core out of reset and zero inputs
// S_FEED  | presenting sig[i]/ker[i] (zero padded) for HOLD cycles each
// S_WAIT  | zero inputs, waiting for conv_done or WAIT_MAX cycles
module conv_1d_feeder #(
    parameter int N        = 5,
    parameter int M        = 3,
    parameter int W        = 8,
    parameter int HOLD     = 2,
    parameter int WAIT_MAX = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    conv_1d_feeder_if.slave   bus_io
);
    localparam int L  = (N > M) ? N : M;
    localparam int AW = (L > 1) ? $clog2(L) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int CW = ($clog2(WAIT_MAX + 1) > 0) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_FEED, S_WAIT} state_t;

    state_t        state_q;
    logic [AW-1:0] i_q;
    logic [HW-1:0] h_q;
    logic [CW-1:0] wcnt_q;
    logic [W-1:0]  sig_q [N];
    logic [W-1:0]  ker_q [M];
    logic [W-1:0]  a_q, b_q;
    logic          conv_rst_q, tick_q, busy_q, run_done_q, timeout_q;

    logic [AW-1:0] i_nxt_d;
    logic [W-1:0]  a_nxt_d, b_nxt_d;

    // Sample for the index about to be presented: 0 when priming, i+1 while feeding.
    always_comb begin
        i_nxt_d = (state_q == S_FEED) ? i_q + 1'b1 : '0;
        a_nxt_d = '0;
        b_nxt_d = '0;
        if (int'(i_nxt_d) < N) a_nxt_d = sig_q[i_nxt_d];
        if (int'(i_nxt_d) < M) b_nxt_d = ker_q[i_nxt_d];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            h_q        <= '0;
            wcnt_q     <= '0;
            for (int k = 0; k < N; k++) sig_q[k] <= '0;
            for (int k = 0; k < M; k++) ker_q[k] <= '0;
            a_q        <= '0;
            b_q        <= '0;
            conv_rst_q <= 1'b1;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            run_done_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            tick_q     <= 1'b0;
            run_done_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus_io.wr_en) begin
                        if (!bus_io.wr_sel && int'(bus_io.wr_addr) < N)
                            sig_q[bus_io.wr_addr] <= bus_io.wr_data;
                        if (bus_io.wr_sel && int'(bus_io.wr_addr) < M)
                            ker_q[bus_io.wr_addr] <= bus_io.wr_data;
                    end
                    if (bus_io.start) begin
                        state_q    <= S_PRIME;
                        conv_rst_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_PRIME: begin
                    state_q <= S_FEED;
                    i_q     <= '0;
                    h_q     <= '0;
                    a_q     <= a_nxt_d;
                    b_q     <= b_nxt_d;
                    tick_q  <= 1'b1;
                end
                S_FEED: begin
                    if (h_q == HW'(HOLD - 1)) begin
                        if (int'(i_q) == L - 1) begin
                            state_q <= S_WAIT;
                            wcnt_q  <= '0;
                            a_q     <= '0;
                            b_q     <= '0;
                        end else begin
                            i_q    <= i_nxt_d;
                            h_q    <= '0;
                            a_q    <= a_nxt_d;
                            b_q    <= b_nxt_d;
                            tick_q <= 1'b1;
                        end
                    end else begin
                        h_q <= h_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    // conv_done is checked first so it wins over an expiring counter.
                    if (bus_io.conv_done) begin
                        state_q    <= S_IDLE;
                        run_done_q <= 1'b1;
                        busy_q     <= 1'b0;
                        conv_rst_q <= 1'b1;
                    end else if (wcnt_q == CW'(WAIT_MAX - 1)) begin
                        state_q    <= S_IDLE;
                        timeout_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        conv_rst_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_io.a           = a_q;
    assign bus_io.b           = b_q;
    assign bus_io.conv_rst    = conv_rst_q;
    assign bus_io.sample_tick = tick_q;
    assign bus_io.busy        = busy_q;
    assign bus_io.run_done    = run_done_q;
    assign bus_io.timeout     = timeout_q;
endmodule
